// File: rtl/lap_stopwatch_pkg.sv
// lap_stopwatch_pkg: state encoding, default parameters and occupancy-width helper.
package lap_stopwatch_pkg;
  typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} sw_state_e;
  localparam int DEF_CNT_W = 32;
  localparam int DEF_TICKS_PER_UNIT = 1;
  localparam int DEF_LAP_DEPTH = 4;
  function automatic int occ_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/lap_stopwatch_if.sv
// lap_stopwatch_if: control, preset and lap readout signals of the stopwatch.
interface lap_stopwatch_if
  import lap_stopwatch_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int LAP_DEPTH = DEF_LAP_DEPTH
);
  logic start;
  logic pause;
  logic restart;
  logic down_mode;
  logic load;
  logic [CNT_W-1:0] preset;
  logic lap;
  logic lap_rd;
  logic [CNT_W-1:0] count;
  logic running;
  logic expired;
  logic [CNT_W-1:0] lap_data;
  logic lap_valid;
  logic [occ_w(LAP_DEPTH)-1:0] lap_count;
  logic lap_overflow;
  modport master (
    output start, pause, restart, down_mode, load, preset, lap, lap_rd,
    input count, running, expired, lap_data, lap_valid, lap_count, lap_overflow
  );
  modport slave (
    input start, pause, restart, down_mode, load, preset, lap, lap_rd,
    output count, running, expired, lap_data, lap_valid, lap_count, lap_overflow
  );
endinterface

// File: rtl/lap_stopwatch_fifo.sv
// lap_fifo: synchronous show-ahead FIFO; a push into a full FIFO is dropped unless a pop frees the slot.
module lap_fifo
  import lap_stopwatch_pkg::*;
#(
  parameter int WIDTH = DEF_CNT_W,
  parameter int DEPTH = DEF_LAP_DEPTH,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = occ_w(DEPTH)
) (
  input  logic clk,
  input  logic clr,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] data,
  output logic valid,
  output logic [CW-1:0] count,
  output logic full
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd, wr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign valid = count != '0;
  assign do_pop = pop && valid;
  assign do_push = push && (!full || pop);
  assign data = valid ? mem[rd] : '0;
  always_ff @(posedge clk)
    if (do_push && !clr) mem[wr] <= din;
  always_ff @(posedge clk) begin
    if (clr) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (do_pop) rd <= rd + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/lap_stopwatch.sv
// lap_stopwatch: prescaled up/down stopwatch with lap FIFO.
// Define LAP_SPLIT_DELTA_EN to store splits between accepted laps instead of absolute counts.
module lap_stopwatch
  import lap_stopwatch_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int TICKS_PER_UNIT = DEF_TICKS_PER_UNIT,
  parameter int LAP_DEPTH = DEF_LAP_DEPTH
) (
  input logic clk,
  input logic r,
  lap_stopwatch_if.slave sw
);
  localparam int PW = TICKS_PER_UNIT > 1 ? $clog2(TICKS_PER_UNIT) : 1;
  sw_state_e state;
  logic [CNT_W-1:0] cnt, lap_val;
  logic [PW-1:0] pre;
  logic dir, running, expired, overflow, full, wrap, push, clr;
  assign wrap = pre == PW'(TICKS_PER_UNIT - 1);
  assign clr = r || sw.restart;
  assign push = sw.lap && state != IDLE;
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= IDLE;
      cnt <= '0;
      pre <= '0;
      running <= 1'b0;
      expired <= 1'b0;
      if (r) dir <= 1'b0;
    end else if (sw.load) begin
      state <= IDLE;
      cnt <= sw.preset;
      pre <= '0;
      dir <= sw.down_mode;
      running <= 1'b0;
      expired <= 1'b0;
    end else begin
      expired <= 1'b0;
      if (state == RUN && sw.pause) begin
        state <= PAUSED;
        running <= 1'b0;
      end else if ((state == IDLE || state == PAUSED) && sw.start && !sw.pause) begin
        state <= RUN;
        running <= 1'b1;
      end else if (state == RUN) begin
        pre <= wrap ? '0 : pre + 1'b1;
        if (wrap) begin
          if (!dir) cnt <= cnt + 1'b1;
          else if (cnt > CNT_W'(1)) cnt <= cnt - 1'b1;
          else begin
            // a zero preset also lands here, so it expires on the first wrap
            cnt <= '0;
            expired <= 1'b1;
            state <= DONE;
            running <= 1'b0;
          end
        end
      end
    end
  end
  always_ff @(posedge clk)
    if (clr) overflow <= 1'b0;
    else if (push && full && !sw.lap_rd) overflow <= 1'b1;
`ifdef LAP_SPLIT_DELTA_EN
  logic [CNT_W-1:0] prev;
  assign lap_val = dir ? prev - cnt : cnt - prev;
  always_ff @(posedge clk)
    if (clr) prev <= '0;
    else if (sw.load) prev <= sw.preset;
    else if (push && (!full || sw.lap_rd)) prev <= cnt;
`else
  assign lap_val = cnt;
`endif
  lap_fifo #(.WIDTH(CNT_W), .DEPTH(LAP_DEPTH)) u_fifo (
    .clk(clk),
    .clr(clr),
    .push(push),
    .pop(sw.lap_rd),
    .din(lap_val),
    .data(sw.lap_data),
    .valid(sw.lap_valid),
    .count(sw.lap_count),
    .full(full)
  );
  assign sw.count = cnt;
  assign sw.running = running;
  assign sw.expired = expired;
  assign sw.lap_overflow = overflow;
endmodule

// File: tb/tb_lap_stopwatch.sv
// tb_lap_stopwatch: self-checking bench; slow instance (2 ticks/unit) and fast instance (1 tick/unit).
module tb_lap_stopwatch;
  logic clk = 1'b0;
  logic r;
  int checks = 0;
  int errors = 0;
  logic [31:0] q[$];
  logic [31:0] prev = '0;
  logic ovf = 1'b0;
  int c;
  always #5 clk = ~clk;
  lap_stopwatch_if #(.CNT_W(32), .LAP_DEPTH(4)) si ();
  lap_stopwatch_if #(.CNT_W(32), .LAP_DEPTH(4)) fi ();
  lap_stopwatch #(.CNT_W(32), .TICKS_PER_UNIT(2), .LAP_DEPTH(4)) u_slow (.clk(clk), .r(r), .sw(si.slave));
  lap_stopwatch #(.CNT_W(32), .TICKS_PER_UNIT(1), .LAP_DEPTH(4)) u_fast (.clk(clk), .r(r), .sw(fi.slave));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic push_lap(input logic [31:0] v);
    logic [31:0] e;
`ifdef LAP_SPLIT_DELTA_EN
    e = v - prev;
`else
    e = v;
`endif
    if (q.size() < 4) begin
      q.push_back(e);
      prev = v;
    end else ovf = 1'b1;
  endtask
  task automatic pop_lap;
    check("lap_valid", fi.lap_valid, 1);
    check("lap_data", fi.lap_data, q.pop_front());
  endtask
  initial begin
    {si.start, si.pause, si.restart, si.down_mode, si.load, si.lap, si.lap_rd} = '0;
    {fi.start, fi.pause, fi.restart, fi.down_mode, fi.load, fi.lap, fi.lap_rd} = '0;
    si.preset = '0;
    fi.preset = '0;
    r = 1'b1;
    tick;
    tick;
    r = 1'b0;
    check("rst_count", fi.count, 0);
    check("rst_running", fi.running, 0);
    check("rst_expired", fi.expired, 0);
    check("rst_valid", fi.lap_valid, 0);
    check("rst_lcount", fi.lap_count, 0);
    check("rst_ovf", fi.lap_overflow, 0);
    check("rst_data", fi.lap_data, 0);
    check("rst_scount", si.count, 0);
    // prescaled up-count
    si.start = 1'b1;
    tick;
    si.start = 1'b0;
    check("t1_running", si.running, 1);
    check("t1_count0", si.count, 0);
    for (int k = 1; k <= 11; k++) begin
      tick;
      check("t1_count", si.count, k / 2);
    end
    // pause mid-prescale, resume keeps prescaler phase
    si.pause = 1'b1;
    tick;
    si.pause = 1'b0;
    check("t2_running", si.running, 0);
    for (int k = 0; k < 10; k++) begin
      tick;
      check("t2_hold", si.count, 5);
    end
    si.start = 1'b1;
    tick;
    si.start = 1'b0;
    check("t2_resume", si.count, 5);
    check("t2_run", si.running, 1);
    tick;
    check("t2_six", si.count, 6);
    // down-count with expiry
    fi.load = 1'b1;
    fi.preset = 32'd3;
    fi.down_mode = 1'b1;
    tick;
    fi.load = 1'b0;
    check("t3_load", fi.count, 3);
    fi.start = 1'b1;
    tick;
    fi.start = 1'b0;
    check("t3_run", fi.count, 3);
    for (int k = 2; k >= 0; k--) begin
      tick;
      check("t3_count", fi.count, k);
      check("t3_expired", fi.expired, k == 0);
    end
    check("t3_done", fi.running, 0);
    tick;
    check("t3_pulse", fi.expired, 0);
    fi.start = 1'b1;
    tick;
    fi.start = 1'b0;
    check("t3_ign_cnt", fi.count, 0);
    check("t3_ign_run", fi.running, 0);
    // zero preset in down mode
    fi.load = 1'b1;
    fi.preset = '0;
    tick;
    fi.load = 1'b0;
    fi.start = 1'b1;
    tick;
    fi.start = 1'b0;
    tick;
    check("z_expired", fi.expired, 1);
    check("z_count", fi.count, 0);
    check("z_running", fi.running, 0);
    // laps while counting up, overflow on the fifth
    fi.load = 1'b1;
    fi.down_mode = 1'b0;
    tick;
    fi.load = 1'b0;
    fi.start = 1'b1;
    tick;
    fi.start = 1'b0;
    c = 0;
    while (c < 12) begin
      fi.lap = (c == 2 || c == 4 || c == 6 || c == 8 || c == 10);
      if (fi.lap) push_lap(32'(c));
      tick;
      c++;
      check("t4_count", fi.count, c);
    end
    fi.lap = 1'b0;
    check("t4_lcount", fi.lap_count, 4);
    check("t4_ovf", fi.lap_overflow, ovf);
    // full: push and pop together
    fi.lap = 1'b1;
    fi.lap_rd = 1'b1;
    pop_lap();
    push_lap(32'(c));
    tick;
    c++;
    fi.lap = 1'b0;
    fi.lap_rd = 1'b0;
    check("t5_lcount", fi.lap_count, 4);
    fi.pause = 1'b1;
    tick;
    fi.pause = 1'b0;
    check("t5_hold", fi.count, c);
    while (q.size() > 0) begin
      pop_lap();
      fi.lap_rd = 1'b1;
      tick;
      fi.lap_rd = 1'b0;
    end
    check("t4_empty", fi.lap_valid, 0);
    check("t4_edata", fi.lap_data, 0);
    check("t4_ecount", fi.lap_count, 0);
    fi.lap_rd = 1'b1;
    tick;
    fi.lap_rd = 1'b0;
    check("rd_empty", fi.lap_count, 0);
    // restart beats start and lap
    fi.start = 1'b1;
    tick;
    fi.start = 1'b0;
    while (c < 20) begin
      fi.lap = (c == 15);
      tick;
      c++;
      check("t6_count", fi.count, c);
    end
    fi.lap = 1'b0;
    check("t6_pre_valid", fi.lap_valid, 1);
    check("t6_pre_ovf", fi.lap_overflow, 1);
    fi.restart = 1'b1;
    fi.start = 1'b1;
    fi.lap = 1'b1;
    tick;
    {fi.restart, fi.start, fi.lap} = '0;
    check("t6_count0", fi.count, 0);
    check("t6_running", fi.running, 0);
    check("t6_valid", fi.lap_valid, 0);
    check("t6_lcount", fi.lap_count, 0);
    check("t6_ovf", fi.lap_overflow, 0);
    tick;
    check("t6_idle", fi.count, 0);
    check("t6_idle_run", fi.running, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/lap_stopwatch.md
Name: lap_stopwatch

Overview:
Parametrised successor to the single-counter stopwatch in the clock/alarm design. Adds a programmable prescaler, an up/down mode with preset load and expiry, and a lap-capture FIFO of configurable depth. Sits beside the clock/alarm block on the same clk and is read by the display/readout logic.

Parameters:
CNT_W, 32, width of the elapsed/remaining count
TICKS_PER_UNIT, 1, clk cycles per count unit (1 = one unit per clk); must be >= 1
LAP_DEPTH, 4, lap FIFO entries; power of two, >= 2

Ports:
clk  in  1  system clock; all logic on rising edge
r  in  1  synchronous active-high reset
start  in  1  level/pulse; begin or resume counting
pause  in  1  suspend counting, hold count
restart  in  1  clear count, prescaler, FIFO and flags; go to IDLE
down_mode  in  1  0 = count up, 1 = count down; sampled only on load
load  in  1  load preset into count; latch down_mode
preset  in  CNT_W  value loaded by load
lap  in  1  capture current count into lap FIFO
lap_rd  in  1  pop FIFO head
count  out  CNT_W  current count
running  out  1  high in RUN
expired  out  1  one-cycle pulse on down-count reaching 0
lap_data  out  CNT_W  FIFO head (show-ahead); 0 when empty
lap_valid  out  1  FIFO non-empty
lap_count  out  $clog2(LAP_DEPTH)+1  occupancy
lap_overflow  out  1  sticky: a lap was dropped because the FIFO was full

Behaviour:
- Reset (r=1): count=0, prescaler=0, dir=up, state=IDLE; FIFO emptied; running=0, expired=0, lap_valid=0, lap_count=0, lap_overflow=0, lap_data=0.
- Control priority per cycle: r > restart > load > pause > start. Pause wins over start when both are asserted.
- States:
  - IDLE: start -> RUN.
  - RUN: pause -> PAUSED; down-count reaching 0 -> DONE.
  - PAUSED: start -> RUN.
  - DONE: start is ignored; load -> IDLE.
- restart from any state -> IDLE, with the same clearing as r except dir keeps its latched value.
- load from any state -> IDLE with count=preset, prescaler=0, dir=down_mode.
- Prescaler: in RUN it counts 0..TICKS_PER_UNIT-1. The count updates in the cycle the prescaler wraps, so the first update occurs TICKS_PER_UNIT cycles after entering RUN. The prescaler holds in PAUSED and does not reset on pause/resume.
- Up mode: count+1, wrapping modulo 2^CNT_W. Wrap does not stop the counter and sets no flag.
- Down mode:
  - count-1.
  - On the update that produces 0: expired=1 for that single cycle, state -> DONE, count holds 0.
  - A load of preset=0 in down mode followed by start goes straight to DONE on the first prescaler wrap, with expired pulsed and count staying 0.
- running = (state==RUN), registered alongside state.
- Lap capture:
  - lap is honoured in RUN, PAUSED and DONE, and ignored in IDLE.
  - The pushed value is count as registered in that cycle, i.e. before any same-cycle update.
  - Push when full: the entry is dropped, FIFO contents are unchanged, and lap_overflow is set.
  - lap_rd when empty is ignored.
  - Simultaneous push and pop:
    - When full: both happen and occupancy is unchanged.
    - When empty: the push only occurs; lap_data shows the new value next cycle.
- lap_data, lap_valid and lap_count are registered and reflect pushes/pops one cycle after the request.
- Reset or restart mid-operation discards FIFO contents immediately (next edge).

Optional Feature:
Macro LAP_SPLIT_DELTA_EN.
- Defined: each FIFO entry holds the split, i.e. the absolute difference between the current count and the count at the previously accepted lap. The "previous lap" register clears to the current count on restart/load/r, is updated only on accepted (non-dropped) pushes, and uses modulo-2^CNT_W subtraction in the counting direction.
- Undefined: entries hold the absolute count; no previous-lap register is synthesised.

Decomposition:
- Package lap_stopwatch_pkg:
  - enum sw_state_e {IDLE, RUN, PAUSED, DONE} (2-bit)
  - default parameter constants
  - function clog2-based occupancy width helper
- Sub-module lap_fifo (synchronous FIFO):
  - parameters WIDTH and DEPTH
  - push/pop/clear inputs
  - data/valid/count/full outputs
- lap_stopwatch owns the FSM, prescaler, counter and overflow flag.

Test Plan:
1. TICKS_PER_UNIT=2. r, then start held one cycle. Required: count=0 for 2 cycles, then 1, 2, 3 every 2 cycles; running=1 from the cycle after start.
2. Up-count to 5, pause for 10 cycles, then start. Required: count holds 5 while paused; it reaches 6 exactly the remaining prescaler cycles after resume (no prescaler reset).
3. load preset=3 with down_mode=1, then start (TICKS_PER_UNIT=1). Required: count goes 3, 2, 1, 0; expired high exactly one cycle, on the 0 update; state DONE; a later start leaves count at 0.
4. LAP_DEPTH=4, counting up. Issue lap at counts 2, 4, 6, 8, 10. Required: lap_count reaches 4, lap_overflow=1, pops return 2, 4, 6, 8, then lap_valid=0. With LAP_SPLIT_DELTA_EN defined the pops return 2, 2, 2, 2.
5. FIFO full; assert lap and lap_rd in the same cycle at count=12. Required: the head pops, 12 is appended, and lap_count stays at 4.
6. restart asserted together with start and lap while in RUN at count=20. Required: next cycle count=0, state IDLE, FIFO empty, lap_overflow=0, running=0.
